// File: rtl/gate_chk_pkg.sv
// Shared types and helpers for the universal-gate self-test checker.
package gate_chk_pkg;

  localparam int PAT_W   = 2;
  localparam int NUM_PAT = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DRIVE,
    ST_SETTLE,
    ST_SAMPLE,
    ST_DONE
  } state_t;

  // Ideal gate response for pattern {a,b}, packed as {nand, nor}.
  function automatic logic [1:0] expected_out(input logic [PAT_W-1:0] pat);
    logic nand_v;
    logic nor_v;
    nand_v = ~(pat[1] & pat[0]);
    nor_v  = ~(pat[1] | pat[0]);
    return {nand_v, nor_v};
  endfunction

endpackage

// File: rtl/gate_chk_expect.sv
// Combinational reference: applied pattern {a,b} -> expected {nand, nor}.
module gate_chk_expect
  import gate_chk_pkg::*;
(
  input  logic [PAT_W-1:0] pattern,
  output logic [1:0]       expected
);

  assign expected = expected_out(pattern);

endmodule

// File: rtl/gate_stimulus_checker.sv
// Built-in self-test wrapper for the NAND/NOR universal gate cell.
// Sweeps {a,b} through 00,01,10,11 for ITERATIONS passes, waits
// SETTLE_CYCLES after each drive, samples the gate and counts mismatches.
// Optional build macro: GATE_CHK_STOP_ON_FAIL_EN (end the run on the
// first mismatching sample instead of finishing the sweep).
//
// state     | meaning
// ----------+-------------------------------------------------
// ST_IDLE   | out of reset, waiting for start
// ST_DRIVE  | load current pattern onto a_out/b_out
// ST_SETTLE | wait SETTLE_CYCLES for the gate to settle
// ST_SAMPLE | compare gate outputs, advance pattern/iteration
// ST_DONE   | result held until the next start
module gate_stimulus_checker
  import gate_chk_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2,
  parameter int ITERATIONS    = 1,
  parameter int ERR_W         = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             nand_in,
  input  logic             nor_in,
  output logic             a_out,
  output logic             b_out,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [3:0]       fail_vec
);

`ifdef GATE_CHK_STOP_ON_FAIL_EN
  localparam bit STOP_ON_FAIL = 1'b1;
`else
  localparam bit STOP_ON_FAIL = 1'b0;
`endif

  // Settle timer only ever holds SETTLE_CYCLES-1; iteration index only ITERATIONS-1.
  localparam int ST_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int IT_W = (ITERATIONS > 1) ? $clog2(ITERATIONS) : 1;

  localparam logic [ST_W-1:0]  SETTLE_LOAD = ST_W'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);
  localparam logic [IT_W-1:0]  ITER_LAST   = IT_W'(ITERATIONS - 1);
  localparam logic [PAT_W-1:0] PAT_LAST    = PAT_W'(NUM_PAT - 1);
  localparam logic [ERR_W-1:0] ERR_MAX     = '1;

  state_t            state;
  state_t            state_nxt;
  logic [PAT_W-1:0]  pattern;
  logic [IT_W-1:0]   iter;
  logic [ST_W-1:0]   settle_cnt;
  logic [1:0]        exp_val;
  logic              mismatch;
  logic              last_sample;

  gate_chk_expect u_expect (
    .pattern  (pattern),
    .expected (exp_val)
  );

  // One error per sample regardless of how many of the two outputs are wrong.
  assign mismatch    = ({nand_in, nor_in} != exp_val);
  assign last_sample = (pattern == PAT_LAST) && (iter == ITER_LAST);

  assign busy = (state == ST_DRIVE) || (state == ST_SETTLE) || (state == ST_SAMPLE);
  assign done = (state == ST_DONE);
  assign pass = done && (err_count == '0);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_nxt = ST_DRIVE;
        end
      end
      ST_DRIVE: begin
        if (SETTLE_CYCLES > 0) begin
          state_nxt = ST_SETTLE;
        end else begin
          state_nxt = ST_SAMPLE;
        end
      end
      ST_SETTLE: begin
        if (settle_cnt == '0) begin
          state_nxt = ST_SAMPLE;
        end
      end
      ST_SAMPLE: begin
        if ((STOP_ON_FAIL && mismatch) || last_sample) begin
          state_nxt = ST_DONE;
        end else begin
          state_nxt = ST_DRIVE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Stimulus, settle timer, pattern sequencing and result accumulation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_out      <= 1'b0;
      b_out      <= 1'b0;
      pattern    <= '0;
      iter       <= '0;
      settle_cnt <= '0;
      err_count  <= '0;
      fail_vec   <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            pattern   <= '0;
            iter      <= '0;
            err_count <= '0;
            fail_vec  <= '0;
          end
        end
        ST_DRIVE: begin
          a_out      <= pattern[1];
          b_out      <= pattern[0];
          settle_cnt <= SETTLE_LOAD;
        end
        ST_SETTLE: begin
          if (settle_cnt != '0) begin
            settle_cnt <= settle_cnt - ST_W'(1);
          end
        end
        ST_SAMPLE: begin
          if (mismatch) begin
            fail_vec[pattern] <= 1'b1;
            if (err_count != ERR_MAX) begin
              err_count <= err_count + ERR_W'(1);
            end
          end
          // Wraps 11 -> 00; stale values after the final sample are cleared on the next start.
          pattern <= pattern + PAT_W'(1);
          if (pattern == PAT_LAST) begin
            iter <= iter + IT_W'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: doc/gate_stimulus_checker.md
Name: gate_stimulus_checker

Overview:
- Self-test stage wrapped around the two-output universal gate (NAND/NOR).
- Drives the gate's a/b inputs through all four input patterns and waits a programmable settle time.
- Samples the gate's NAND/NOR outputs, compares them against expected values, and accumulates a pass/fail result.
- Used as a power-on or on-demand built-in self-test for the gate cell.

Parameters:
- SETTLE_CYCLES, 2, number of idle cycles between driving a pattern and sampling the outputs; 0 is legal and skips SETTLE.
- ITERATIONS, 1, number of full 4-pattern sweeps per run; must be at least 1.
- ERR_W, 8, width of the mismatch counter.

Ports:
- clk  input  1  single system clock; all logic on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  run request; sampled only in IDLE or DONE.
- nand_in  input  1  gate NAND output under test.
- nor_in  input  1  gate NOR output under test.
- a_out  output  1  gate input a; registered.
- b_out  output  1  gate input b; registered.
- busy  output  1  high while a run is in progress.
- done  output  1  high from run completion until the next accepted start.
- pass  output  1  done && err_count==0.
- err_count  output  ERR_W  number of mismatching samples in the run; saturates.
- fail_vec  output  4  sticky per-pattern failure flags; bit index = {a,b}.

Behaviour:
- Reset (async assert, sync release):
  - All outputs go to 0 and the state goes to IDLE.
  - Reset mid-run aborts the run; no partial result is retained.
- FSM states: IDLE, DRIVE, SETTLE, SAMPLE, DONE.
  - IDLE/DONE with start=1: clear err_count and fail_vec, set pattern=00 and iteration=0, go to DRIVE; busy=1 and done=0 from that edge.
  - DRIVE (1 cycle): a_out/b_out <= pattern[1]/pattern[0]. Next state is SETTLE if SETTLE_CYCLES>0, else SAMPLE.
  - SETTLE: lasts exactly SETTLE_CYCLES cycles, then SAMPLE.
  - SAMPLE (1 cycle): compare nand_in to ~(a&b) and nor_in to ~(a|b).
    - Any mismatch: err_count += 1, counted once per sample even if both outputs mismatch; saturates at all-ones. Also set fail_vec[pattern].
    - Then advance: if pattern==11 and this is the last iteration, go to DONE; otherwise increment pattern (11 wraps to 00, iteration += 1) and go to DRIVE.
  - DONE: busy=0, done=1, and err_count, fail_vec and pass are held.
- Timing and inputs:
  - Run length: done rises exactly ITERATIONS*4*(SETTLE_CYCLES+2) edges after the edge that sampled start. Defaults: 16 cycles.
  - start while busy is ignored; no restart or queueing.
  - a_out/b_out hold their last pattern (11) in DONE and return to 0 only on reset.
  - nand_in/nor_in are assumed to be settled by SAMPLE; no synchronizer, because the gate is in the same clock domain.

Optional Feature:
- Macro GATE_CHK_STOP_ON_FAIL_EN.
- Defined: on the first mismatching SAMPLE, record the error (err_count=1, fail_vec bit set) and go directly to DONE on the next edge. The remaining patterns and iterations are skipped.
- Undefined: the full sweep always completes and all mismatches are counted.

Decomposition:
- Package gate_chk_pkg holds:
  - the state enum (5 states);
  - the PAT_W=2 constant and NUM_PAT=4;
  - the expected-value function returning {nand,nor} for a 2-bit pattern.
- One sub-module, gate_chk_expect: combinational reference model, pattern -> expected {nand,nor}. It is reused by the bench scoreboard.

Test Plan:
- Defaults, correct gate connected, start pulse -> a/b sequence 00,01,10,11, each held 4 cycles; done at +16; pass=1; err_count=0; fail_vec=0000.
- Gate with nor_in stuck at 0 -> pattern 00 mismatches; err_count=1, fail_vec=0001, pass=0.
- Inverted NAND (AND behaviour), ITERATIONS=3 -> err_count=12, fail_vec=1111, done at +48.
- ERR_W=2, constant-wrong model, ITERATIONS=2 -> 8 mismatches; err_count saturates at 3.
- rst_n pulsed low during SETTLE of pattern 10 -> all outputs 0 immediately. A new start afterwards gives a clean run with pass=1. A start pulsed while busy has no effect on timing.
- GATE_CHK_STOP_ON_FAIL_EN defined, fault on pattern 01 -> done 8 cycles after start; err_count=1; fail_vec=0010; a_out/b_out hold 0/1.
